// File: rtl/baud_gen_os.sv
// Fractional baud-tick generator with independent TX and RX channels.
// A subtractive phase accumulator (acc += inc; acc -= freq on wrap) produces
// ticks at freq/inc intervals without multipliers. The RX channel runs at
// OS x baud and derives a mid-bit sample tick from the oversample count.
module baud_gen_os #(
    parameter int CLK_W   = 32,
    parameter int BAUD_W  = 24,
    parameter int OS_LOG2 = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CLK_W-1:0]  cfg_clk_freq,
    input  logic [BAUD_W-1:0] cfg_baud_rate,
    input  logic [1:0]        cfg_data_bits,
    input  logic [1:0]        cfg_parity_type,
    input  logic [1:0]        cfg_stop_bit,
    input  logic              tx_start,
    output logic              tx_ce,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              rx_start,
    output logic              rx_os_ce,
    output logic              rx_ce,
    output logic              rx_busy,
    output logic              rx_done,
    output logic              cfg_err
);

    localparam int ACC_W = CLK_W + 1;
    // Oversample index whose tick lands in the middle of a bit
    localparam logic [OS_LOG2-1:0] OS_MID = OS_LOG2'((32'd1 << (OS_LOG2 - 1)) - 32'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Frame length in bits: start + data + optional parity + stop bits
    function automatic logic [CNT_W-1:0] frame_len(
        input logic [1:0] data_bits,
        input logic [1:0] parity_type,
        input logic [1:0] stop_bit
    );
        logic [CNT_W-1:0] len;
        len = CNT_W'(3'd6) + CNT_W'(data_bits);
        if (parity_type != 2'd0) len = len + CNT_W'(1'b1);
        else                     len = len;
        if (stop_bit >= 2'd2)    len = len + CNT_W'(2'd2);
        else                     len = len + CNT_W'(1'b1);
        return len;
    endfunction

    // Configuration-derived values
    logic [ACC_W-1:0] freq_ext_s;
    logic [ACC_W-1:0] inc_bit_s;
    logic [ACC_W-1:0] inc_os_s;
    logic [CNT_W-1:0] fl_last_s;
    logic             cfg_err_s;

    assign freq_ext_s = ACC_W'(cfg_clk_freq);
    assign inc_bit_s  = ACC_W'(cfg_baud_rate);
    assign inc_os_s   = inc_bit_s << OS_LOG2;
    assign fl_last_s  = frame_len(cfg_data_bits, cfg_parity_type, cfg_stop_bit) - CNT_W'(1'b1);
    assign cfg_err_s  = (cfg_baud_rate == {BAUD_W{1'b0}}) || (inc_os_s > freq_ext_s);

    // TX channel state
    state_t           tx_state_r, tx_state_nxt_s;
    logic [ACC_W-1:0] tx_acc_r, tx_freq_r, tx_inc_r, tx_sum_s;
    logic [CNT_W-1:0] tx_bit_cnt_r, tx_fl_last_r;
    logic             tx_ce_r, tx_done_r, tx_busy_r, tx_hit_s, tx_start_ok_s;

    // RX channel state
    state_t             rx_state_r, rx_state_nxt_s;
    logic [ACC_W-1:0]   rx_acc_r, rx_freq_r, rx_inc_r, rx_sum_s;
    logic [CNT_W-1:0]   rx_bit_cnt_r, rx_fl_last_r;
    logic [OS_LOG2-1:0] rx_os_cnt_r;
    logic               rx_os_ce_r, rx_ce_r, rx_done_r, rx_busy_r, rx_hit_s, rx_start_ok_s;
    logic               cfg_err_r;

    assign tx_sum_s      = tx_acc_r + tx_inc_r;
    assign tx_hit_s      = (tx_sum_s >= tx_freq_r);
    assign tx_start_ok_s = tx_start && !cfg_err_s && (tx_state_r == ST_IDLE);

    assign rx_sum_s      = rx_acc_r + rx_inc_r;
    assign rx_hit_s      = (rx_sum_s >= rx_freq_r);
    assign rx_start_ok_s = rx_start && !cfg_err_s;

    // Configuration error flag, registered every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_r <= 1'b0;
        else        cfg_err_r <= cfg_err_s;
    end

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_r <= ST_IDLE;
        else        tx_state_r <= tx_state_nxt_s;
    end

    // TX next state: leave RUN in the cycle the done pulse is visible
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            ST_IDLE: begin
                if (tx_start_ok_s) tx_state_nxt_s = ST_RUN;
                else               tx_state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (tx_done_r) tx_state_nxt_s = ST_IDLE;
                else           tx_state_nxt_s = ST_RUN;
            end
            default: tx_state_nxt_s = ST_IDLE;
        endcase
    end

    // TX accumulator, bit counter, latched config and output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_acc_r     <= {ACC_W{1'b0}};
            tx_freq_r    <= {ACC_W{1'b0}};
            tx_inc_r     <= {ACC_W{1'b0}};
            tx_bit_cnt_r <= {CNT_W{1'b0}};
            tx_fl_last_r <= {CNT_W{1'b0}};
            tx_ce_r      <= 1'b0;
            tx_done_r    <= 1'b0;
            tx_busy_r    <= 1'b0;
        end else begin
            tx_ce_r   <= 1'b0;
            tx_done_r <= 1'b0;
            if (tx_start_ok_s) begin
                tx_acc_r     <= inc_bit_s;
                tx_inc_r     <= inc_bit_s;
                tx_freq_r    <= freq_ext_s;
                tx_fl_last_r <= fl_last_s;
                tx_bit_cnt_r <= {CNT_W{1'b0}};
                tx_busy_r    <= 1'b1;
            end else if ((tx_state_r == ST_RUN) && !tx_done_r) begin
                if (tx_hit_s) begin
                    tx_acc_r     <= tx_sum_s - tx_freq_r;
                    tx_ce_r      <= 1'b1;
                    tx_done_r    <= (tx_bit_cnt_r == tx_fl_last_r);
                    tx_bit_cnt_r <= tx_bit_cnt_r + CNT_W'(1'b1);
                end else begin
                    tx_acc_r <= tx_sum_s;
                end
            end else if (tx_state_r == ST_RUN) begin
                tx_busy_r <= 1'b0;
            end else begin
                tx_busy_r <= 1'b0;
            end
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_r <= ST_IDLE;
        else        rx_state_r <= rx_state_nxt_s;
    end

    // RX next state: a start (restart) always wins over frame completion
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            ST_IDLE: begin
                if (rx_start_ok_s) rx_state_nxt_s = ST_RUN;
                else               rx_state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (rx_start_ok_s)  rx_state_nxt_s = ST_RUN;
                else if (rx_done_r) rx_state_nxt_s = ST_IDLE;
                else                rx_state_nxt_s = ST_RUN;
            end
            default: rx_state_nxt_s = ST_IDLE;
        endcase
    end

    // RX oversample accumulator, mid-bit sampling and frame counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_acc_r     <= {ACC_W{1'b0}};
            rx_freq_r    <= {ACC_W{1'b0}};
            rx_inc_r     <= {ACC_W{1'b0}};
            rx_bit_cnt_r <= {CNT_W{1'b0}};
            rx_fl_last_r <= {CNT_W{1'b0}};
            rx_os_cnt_r  <= {OS_LOG2{1'b0}};
            rx_os_ce_r   <= 1'b0;
            rx_ce_r      <= 1'b0;
            rx_done_r    <= 1'b0;
            rx_busy_r    <= 1'b0;
        end else begin
            rx_os_ce_r <= 1'b0;
            rx_ce_r    <= 1'b0;
            rx_done_r  <= 1'b0;
            if (rx_start_ok_s) begin
                rx_acc_r     <= inc_os_s;
                rx_inc_r     <= inc_os_s;
                rx_freq_r    <= freq_ext_s;
                rx_fl_last_r <= fl_last_s;
                rx_bit_cnt_r <= {CNT_W{1'b0}};
                rx_os_cnt_r  <= {OS_LOG2{1'b0}};
                rx_busy_r    <= 1'b1;
            end else if ((rx_state_r == ST_RUN) && !rx_done_r) begin
                if (rx_hit_s) begin
                    rx_acc_r    <= rx_sum_s - rx_freq_r;
                    rx_os_ce_r  <= 1'b1;
                    rx_os_cnt_r <= rx_os_cnt_r + OS_LOG2'(1'b1);
                    if (rx_os_cnt_r == OS_MID) begin
                        rx_ce_r      <= 1'b1;
                        rx_done_r    <= (rx_bit_cnt_r == rx_fl_last_r);
                        rx_bit_cnt_r <= rx_bit_cnt_r + CNT_W'(1'b1);
                    end else begin
                        rx_ce_r <= 1'b0;
                    end
                end else begin
                    rx_acc_r <= rx_sum_s;
                end
            end else begin
                rx_busy_r <= 1'b0;
            end
        end
    end

    assign tx_ce    = tx_ce_r;
    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;
    assign rx_os_ce = rx_os_ce_r;
    assign rx_ce    = rx_ce_r;
    assign rx_busy  = rx_busy_r;
    assign rx_done  = rx_done_r;
    assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_baud_gen_os.sv
// Self-checking bench for baud_gen_os: directed scenarios plus randomized
// frames, with expected tick cycles computed arithmetically and checked by a
// monitor that pops a scoreboard queue whenever the DUT pulses a tick.
module tb_baud_gen_os;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_clk_freq;
    logic [23:0] cfg_baud_rate;
    logic [1:0]  cfg_data_bits, cfg_parity_type, cfg_stop_bit;
    logic        tx_start, tx_ce, tx_busy, tx_done;
    logic        rx_start, rx_os_ce, rx_ce, rx_busy, rx_done, cfg_err;

    baud_gen_os dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_clk_freq(cfg_clk_freq), .cfg_baud_rate(cfg_baud_rate),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_type(cfg_parity_type),
        .cfg_stop_bit(cfg_stop_bit),
        .tx_start(tx_start), .tx_ce(tx_ce), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_start(rx_start), .rx_os_ce(rx_os_ce), .rx_ce(rx_ce),
        .rx_busy(rx_busy), .rx_done(rx_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit ce; bit done; } ev_t;
    ev_t tx_q[$];
    ev_t rx_q[$];
    ev_t mon_e;
    int  tx_s = 0, tx_end = 0, rx_s = 0, rx_end = 0;
    int  checks = 0, failures = 0;
    bit  err_last = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_err();
        longint f, b;
        f = cfg_clk_freq;
        b = cfg_baud_rate;
        return (b == 0) || (b * 16 > f);
    endfunction

    function automatic int model_fl();
        return 1 + 5 + int'(cfg_data_bits) + ((cfg_parity_type != 2'd0) ? 1 : 0)
               + ((cfg_stop_bit >= 2'd2) ? 2 : 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input longint f, input longint b, input int db, input int par, input int stop);
        cfg_clk_freq    = f[31:0];
        cfg_baud_rate   = b[23:0];
        cfg_data_bits   = db[1:0];
        cfg_parity_type = par[1:0];
        cfg_stop_bit    = stop[1:0];
    endtask

    // Issue starts in the current cycle and push the expected tick schedule:
    // the k-th tick of a stream with rate r lands ceil(k*freq/r) cycles later.
    task automatic go(input bit do_tx, input bit do_rx);
        int     c, fl, k_tot;
        longint f, b, n;
        bit     err;
        ev_t    e;
        tx_start = do_tx;
        rx_start = do_rx;
        c   = cyc;
        err = model_err();
        f   = cfg_clk_freq;
        b   = cfg_baud_rate;
        fl  = model_fl();
        if (do_tx && !err && c > tx_end) begin
            for (int k = 1; k <= fl; k++) begin
                n = (longint'(k) * f + b - 1) / b;
                e.cyc = c + int'(n); e.ce = 1'b1; e.done = (k == fl);
                tx_q.push_back(e);
            end
            tx_s   = c;
            tx_end = tx_q[$].cyc;
        end
        if (do_rx && !err) begin
            while (rx_q.size() > 0 && rx_q[$].cyc > c) void'(rx_q.pop_back());
            if (!(c > rx_s && c <= rx_end)) rx_s = c;
            k_tot = 8 + 16 * (fl - 1);
            for (int k = 1; k <= k_tot; k++) begin
                n = (longint'(k) * f + 16 * b - 1) / (16 * b);
                e.cyc = c + int'(n);
                e.ce = (k >= 8) && (((k - 8) % 16) == 0);
                e.done = (k == k_tot);
                rx_q.push_back(e);
            end
            rx_end = rx_q[$].cyc;
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        rx_start = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 40000;
        while ((cyc <= tx_end + 1 || cyc <= rx_end + 1) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) chk("wait_timeout", cyc, (tx_end > rx_end) ? tx_end : rx_end);
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);
        tx_q.delete();
        rx_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_ce"}, tx_ce, 0);
        chk({tag, "_tx_busy"}, tx_busy, 0);
        chk({tag, "_tx_done"}, tx_done, 0);
        chk({tag, "_rx_os_ce"}, rx_os_ce, 0);
        chk({tag, "_rx_ce"}, rx_ce, 0);
        chk({tag, "_rx_busy"}, rx_busy, 0);
        chk({tag, "_rx_done"}, rx_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Monitor: compare every pulse and busy level against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cfg_err", cfg_err, err_last);
            err_last = model_err();
            while (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
                chk("tx_ce_missing", cyc, tx_q[0].cyc);
                void'(tx_q.pop_front());
            end
            if (tx_ce) begin
                if (tx_q.size() == 0) chk("tx_ce_unexpected", tx_ce, 0);
                else begin
                    mon_e = tx_q.pop_front();
                    chk("tx_ce_cycle", cyc, mon_e.cyc);
                    chk("tx_done_flag", tx_done, mon_e.done);
                end
            end else chk("tx_done_without_ce", tx_done, 0);
            chk("tx_busy", tx_busy, (cyc > tx_s && cyc <= tx_end));
            while (rx_q.size() > 0 && rx_q[0].cyc < cyc) begin
                chk("rx_os_ce_missing", cyc, rx_q[0].cyc);
                void'(rx_q.pop_front());
            end
            if (rx_os_ce) begin
                if (rx_q.size() == 0) chk("rx_os_ce_unexpected", rx_os_ce, 0);
                else begin
                    mon_e = rx_q.pop_front();
                    chk("rx_os_ce_cycle", cyc, mon_e.cyc);
                    chk("rx_ce_flag", rx_ce, mon_e.ce);
                    chk("rx_done_flag", rx_done, mon_e.done);
                end
            end else begin
                chk("rx_ce_without_os", rx_ce, 0);
                chk("rx_done_without_os", rx_done, 0);
            end
            chk("rx_busy", rx_busy, (cyc > rx_s && cyc <= rx_end));
        end else begin
            err_last = 1'b0;
        end
    end

    initial begin
        int b, f;
        rst_n = 1'b1;
        tx_start = 1'b0;
        rx_start = 1'b0;
        set_cfg(100, 10, 3, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 100 Hz / 10 baud, 8N1 TX
        go(1'b1, 1'b0);
        wait_done();

        // 160 / 1 baud, 8N1 RX
        set_cfg(160, 1, 3, 0, 0);
        tick(1);
        go(1'b0, 1'b1);
        wait_done();

        // Frame formats; mid-frame config change must not matter
        set_cfg(100, 10, 0, 0, 0);
        tick(1);
        go(1'b1, 1'b0);
        tick(30);
        cfg_data_bits = 2'd3;
        wait_done();
        set_cfg(100, 10, 3, 1, 2);
        tick(1);
        go(1'b1, 1'b0);
        wait_done();

        // Non-integer ratio 1000/3
        set_cfg(1000, 3, 3, 0, 0);
        tick(1);
        go(1'b1, 1'b0);
        wait_done();

        // Invalid configurations refuse starts
        set_cfg(100, 0, 3, 0, 0);
        tick(2);
        go(1'b1, 1'b1);
        tick(20);
        set_cfg(100, 7, 3, 0, 0);
        tick(2);
        go(1'b1, 1'b1);
        tick(20);

        // RX restart 500 cycles into a frame
        set_cfg(160, 1, 3, 0, 0);
        tick(1);
        go(1'b0, 1'b1);
        tick(499);
        go(1'b0, 1'b1);
        wait_done();

        // Simultaneous starts, then asynchronous reset mid-frame
        go(1'b1, 1'b1);
        tick(237);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        tx_q.delete();
        rx_q.delete();
        tx_s = 0; tx_end = 0; rx_s = 0; rx_end = 0;
        tick(2);
        rst_n = 1'b1;
        set_cfg(100, 10, 3, 0, 0);
        tick(1);
        go(1'b1, 1'b0);
        wait_done();

        // Randomized configurations with overlapping starts and restarts
        for (int it = 0; it < 8; it++) begin
            b = $urandom_range(1, 4);
            f = b * 16 + $urandom_range(0, 60);
            set_cfg(f, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            tick(1);
            go(1'b1, 1'($urandom_range(0, 1)));
            for (int j = 0; j < 3; j++) begin
                tick($urandom_range(20, 400));
                go(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baud_gen_os.md
Name: baud_gen_os

Overview:
- Parametrised fractional baud-tick generator for the UART controller; successor to the fixed 8-bit, multiply-based tick generator.
- Uses a subtractive phase accumulator, so no multipliers are needed.
- Supports a configurable frame format: 5–8 data bits, optional parity, 1/2 stop bits.
- Produces three tick streams:
  - a per-bit tick for the TX shifter;
  - an oversampled tick for the RX filter;
  - a mid-bit sample tick for the RX shifter.
- Each direction has frame-level busy/done status and a configuration-error flag.

Parameters:
CLK_W, 32, width of cfg_clk_freq (Hz)
BAUD_W, 24, width of cfg_baud_rate (baud)
OS_LOG2, 4, log2 of RX oversampling factor OS (OS=16)
CNT_W, 4, width of bit counters (frame length max 12)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_clk_freq  in  CLK_W  clock frequency in Hz
cfg_baud_rate  in  BAUD_W  baud rate
cfg_data_bits  in  2  data bits: 0=5, 1=6, 2=7, 3=8
cfg_parity_type  in  2  0 = no parity bit; any other value adds 1 bit
cfg_stop_bit  in  2  0 or 1 = 1 stop bit; 2 or 3 = 2 stop bits
tx_start  in  1  single-cycle request to begin a TX frame
tx_ce  out  1  one-cycle pulse on the last cycle of each TX bit
tx_busy  out  1  TX frame in progress
tx_done  out  1  pulse coincident with the final tx_ce of a frame
rx_start  in  1  start-edge detected by the RX core (single cycle)
rx_os_ce  out  1  oversample tick at OS*baud
rx_ce  out  1  mid-bit sample tick
rx_busy  out  1  RX frame in progress
rx_done  out  1  pulse coincident with the final rx_ce of a frame
cfg_err  out  1  configuration invalid

Behaviour:
- Reset: all outputs 0; accumulators, counters and latched configuration cleared. Reset is asynchronous, release is synchronous to clk.
- cfg_err:
  - Registered every cycle.
  - Set to 1 when cfg_baud_rate==0 or (cfg_baud_rate<<OS_LOG2) > cfg_clk_freq.
  - A tx_start or rx_start sampled while the *combinational* error condition is true is refused: the channel stays idle.
- Frame length: FL = 1 + (5+cfg_data_bits) + (cfg_parity_type!=0) + (cfg_stop_bit>=2 ? 2 : 1). Range 7..12.
- Latching: FL, cfg_clk_freq and cfg_baud_rate are latched per channel when a start is accepted. Config changes mid-frame have no effect until the next start.
- Accumulator:
  - Width CLK_W+1 bits, unsigned.
  - Each active cycle: sum = acc + inc.
  - If sum >= freq: acc <= sum - freq and a tick is registered for the next cycle; else acc <= sum.
  - No multiply; OS scaling is a left shift.
- TX FSM (IDLE / RUN):
  - IDLE: tx_start accepted → RUN. acc <= baud, bit_cnt <= 0, tx_busy <= 1. TX inc = baud.
  - RUN: each tick raises tx_ce and increments bit_cnt. On the tick where bit_cnt == FL-1, tx_done is also raised; next state is IDLE and tx_busy <= 0.
  - Timing: with D = freq/baud an integer and tx_start high in cycle 0, tx_busy is high in cycles 1..FL*D and tx_ce fires in cycles D, 2D, …, FL*D.
  - For non-integer ratios, the long-term tick period equals freq/baud, with jitter ≤ 1 cycle.
  - tx_start during RUN is ignored.
- RX FSM (IDLE / RUN):
  - Start: rx_start accepted in IDLE or in RUN (resync/restart). acc <= baud<<OS_LOG2, os_cnt <= 0, bit_cnt <= 0, rx_busy <= 1. RX inc = baud<<OS_LOG2.
  - Each accumulator tick raises rx_os_ce and advances os_cnt (modulo OS).
  - rx_ce first fires on the OS/2-th oversample tick (mid start bit), then every OS ticks.
  - On the rx_ce where bit_cnt == FL-1, rx_done is also raised; next state is IDLE and rx_busy <= 0.
  - rx_os_ce is only generated while rx_busy is high.
- Independence: TX and RX are fully independent. Simultaneous tx_start and rx_start are both accepted. A start arriving in the same cycle as the final tick: the final tick/done completes. For RX the restart takes priority, so the done pulse is suppressed and the counters reload.
- Mid-frame reset: all outputs drop to 0 immediately (asynchronous). The first start after reset release is accepted normally.

Test Plan:
- freq=100, baud=10, 8N1 (FL=10), tx_start in cycle 0 → tx_ce in cycles 10,20,…,100; tx_done in cycle 100; tx_busy high in cycles 1..100, low in cycle 101.
- freq=160, baud=1, OS=16, 8N1, rx_start in cycle 0 → rx_os_ce every 10 cycles from cycle 10; rx_ce in cycles 80,240,…,1520 (10 pulses); rx_done in cycle 1520.
- Frame formats: 5-bit/no parity/1 stop → 7 tx_ce; 8-bit/parity/2 stop → 12 tx_ce. Changing cfg_data_bits mid-frame does not alter the current count.
- freq=1000, baud=3, TX over 3000 cycles → exactly 9 tx_ce; consecutive spacing of 333 or 334 cycles.
- Errors: baud=0 or baud*16 > freq → cfg_err=1 and tx_start/rx_start ignored (busy stays 0). rx_start at cycle 500 of an RX frame → counters restart and the next rx_ce lands 80 cycles later (freq=160, baud=1).
- rst_n pulsed low mid-TX and mid-RX → all outputs 0 within the same cycle; a fresh tx_start after release reproduces the first scenario's timing.
